// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output slot: takes a word on wr, offers it until the sink drains it.
// state | meaning
// SLOT_EMPTY | no word held, data keeps last value
// SLOT_FULL  | word held and offered on valid/data
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output slot_state_t      state
);

  slot_state_t      state_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (wr) begin
            state_q <= SLOT_FULL;
            valid_q <= 1'b1;
            data_q  <= wr_data;
          end
        end
        SLOT_FULL: begin
          // A write while full only arrives together with a drain, so it replaces the word.
          if (wr) begin
            data_q <= wr_data;
          end else if (rd_ready) begin
            state_q <= SLOT_EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= SLOT_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign state = state_q;

endmodule

// File: rtl/demux_stream.sv
// Registered 1:2 stream demux steering each word by in_sel into one of two slots.
// Optional per-output accepted-word counters are built when DEMUX_CNT_EN is defined.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
`endif
);

  slot_state_t state0, state1;
  logic        can0, can1;
  logic        wr0, wr1;

  // Ready only looks at the selected slot, so a stalled sink never blocks the other path.
  assign can0     = (state0 == SLOT_EMPTY) | out0_ready;
  assign can1     = (state1 == SLOT_EMPTY) | out1_ready;
  assign in_ready = in_sel ? can1 : can0;
  assign wr0      = in_valid & in_ready & ~in_sel;
  assign wr1      = in_valid & in_ready & in_sel;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr0),
    .wr_data  (in_data),
    .rd_ready (out0_ready),
    .valid    (out0_valid),
    .data     (out0_data),
    .state    (state0)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr1),
    .wr_data  (in_data),
    .rd_ready (out1_ready),
    .valid    (out1_valid),
    .data     (out1_data),
    .state    (state1)
  );

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (wr0 && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + 16'd1;
      if (wr1 && (cnt1_q != CNT_MAX)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign out0_count = cnt0_q;
  assign out1_count = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus random traffic against a queue model.
module tb_demux_stream;
  import demux_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sel;
  logic [15:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [15:0] out0_data, out1_data;
`ifdef DEMUX_CNT_EN
  logic [15:0] out0_count, out1_count;
`endif

  demux_stream #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words in flight per output, last word written per output, write counts.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] last0, last1;
  int          cnt0, cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    cnt0  = 0;
    cnt1  = 0;
  endtask

  // One clock: drive at the falling edge, check ready before the rise, outputs after it.
  task automatic cyc(input logic v, input logic s, input logic [15:0] d,
                     input logic r0, input logic r1);
    logic        er;
    logic [15:0] o0, o1;
    logic [15:0] w;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    er = s ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    o0 = out0_data;
    o1 = out1_data;
    @(posedge clk);
    if (r0 && q0.size() > 0) begin
      w = q0.pop_front();
      chk("drain0_order", {16'd0, o0}, {16'd0, w});
    end
    if (r1 && q1.size() > 0) begin
      w = q1.pop_front();
      chk("drain1_order", {16'd0, o1}, {16'd0, w});
    end
    if (v && er) begin
      if (s) begin
        q1.push_back(d);
        last1 = d;
        cnt1  = (cnt1 < 65535) ? cnt1 + 1 : 65535;
      end else begin
        q0.push_back(d);
        last0 = d;
        cnt0  = (cnt0 < 65535) ? cnt0 + 1 : 65535;
      end
    end
    #1;
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    chk("out0_data", {16'd0, out0_data}, {16'd0, last0});
    chk("out1_data", {16'd0, out1_data}, {16'd0, last1});
`ifdef DEMUX_CNT_EN
    chk("out0_count", {16'd0, out0_count}, cnt0);
    chk("out1_count", {16'd0, out1_count}, cnt1);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid0", {31'd0, out0_valid}, 32'd0);
    chk("rst_valid1", {31'd0, out1_valid}, 32'd0);
    chk("rst_data0", {16'd0, out0_data}, 32'd0);
    chk("rst_data1", {16'd0, out1_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single route to out1 with a stalled sink.
    cyc(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0);
    chk("route_v1", {31'd0, out1_valid}, 32'd1);
    chk("route_d1", {16'd0, out1_data}, 32'h0000A5A5);
    cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Back-to-back stream into out0.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
      chk("stream_d0", {16'd0, out0_data}, i);
    end
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Stall isolation: slot0 stuck full, slot1 still accepts.
    cyc(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
    chk("stall_hold0", {16'd0, out0_data}, 32'h00001111);
    chk("stall_acc1", {16'd0, out1_data}, 32'h00002222);
    cyc(1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);

    // Simultaneous drain and write on slot1.
    cyc(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h4444, 1'b0, 1'b1);
    chk("sim_v1", {31'd0, out1_valid}, 32'd1);
    chk("sim_d1", {16'd0, out1_data}, 32'h00004444);

    // Reset mid-stream with both slots full.
    do_reset();

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef DEMUX_CNT_EN
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      cyc(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
    end
    chk("cnt0_sat", {16'd0, out0_count}, 32'h0000FFFF);
    chk("cnt1_zero", {16'd0, out1_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
